// File: rtl/liang_pkg.sv
// liang_pkg: shared types and constants for the liang core.
//   pc_t / inst_t / paddr_t : 32-bit address and instruction words
//   ifToId_t                : fetch-to-decode payload {pc, inst}
//   ifu_state_e             : fetch unit FSM encoding
//   LIANG_RESET_PC          : default first fetch address
package liang_pkg;

  typedef logic [31:0] pc_t;
  typedef logic [31:0] inst_t;
  typedef logic [31:0] paddr_t;

  typedef struct packed {
    pc_t   pc;
    inst_t inst;
  } ifToId_t;

  typedef enum logic [1:0] {
    IFU_IDLE = 2'd0,
    IFU_REQ  = 2'd1,
    IFU_WAIT = 2'd2
  } ifu_state_e;

  localparam pc_t LIANG_RESET_PC = 32'h8000_0000;

  // Instructions are word aligned; low two bits of any target are dropped.
  function automatic pc_t align_pc(input pc_t p);
    return {p[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/liang_pipe_reg.sv
// liang_pipe_reg: single-entry valid/ready stage register with flush.
//   clk, rst              : clock, async active-high reset
//   flush                 : drop the held entry, refuse any load this cycle
//   in_valid/in_ready     : upstream handshake, in_data payload
//   out_valid/out_ready   : downstream handshake, out_data payload
// Handshake rule (both sides): a transfer happens on a rising edge where
// valid and ready are both high; valid must not depend on ready.
module liang_pipe_reg #(
  parameter type T = logic [31:0]
) (
  input  logic clk,
  input  logic rst,
  input  logic flush,
  input  logic in_valid,
  output logic in_ready,
  input  T     in_data,
  output logic out_valid,
  input  logic out_ready,
  output T     out_data
);

  logic valid_q;
  T     data_q;
  logic load;

  // Accept when empty or when the held entry leaves this same cycle.
  assign in_ready  = !valid_q || out_ready;
  assign load      = in_valid && in_ready && !flush;
  assign out_valid = valid_q;
  assign out_data  = data_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      if (flush)          valid_q <= 1'b0;
      else if (load)      valid_q <= 1'b1;
      else if (out_ready) valid_q <= 1'b0;
      if (load) data_q <= in_data;
    end
  end

endmodule

// File: rtl/liang_ifu.sv
// liang_ifu: instruction fetch stage, one outstanding imem read at a time.
//   clk, rst                         : clock, async active-high reset
//   redirect_valid_i/redirect_pc_i   : restart fetch at a new PC (flush)
//   imem_req_*                       : request channel (addr = current pc)
//   imem_rsp_*                       : response channel (instruction word)
//   if_valid_o/if_ready_i/if_data_o  : {pc, inst} to decode
// Handshake rule (all channels): a transfer happens on a rising edge where
// valid and ready are both high; valid must not depend on ready.
module liang_ifu
  import liang_pkg::*;
#(
  parameter pc_t RESET_PC = LIANG_RESET_PC
) (
  input  logic    clk,
  input  logic    rst,
  input  logic    redirect_valid_i,
  input  pc_t     redirect_pc_i,
  output logic    imem_req_valid_o,
  input  logic    imem_req_ready_i,
  output paddr_t  imem_req_addr_o,
  input  logic    imem_rsp_valid_i,
  input  inst_t   imem_rsp_data_i,
  output logic    imem_rsp_ready_o,
  output logic    if_valid_o,
  input  logic    if_ready_i,
  output ifToId_t if_data_o
);

  ifu_state_e state;
  pc_t        pc;
  logic       kill;

  logic    out_in_ready;
  logic    out_in_valid;
  ifToId_t out_in_data;
  logic    req_fire;
  logic    rsp_fire;

  assign imem_req_valid_o = (state == IFU_REQ);
  assign imem_req_addr_o  = pc;

  // A killed or redirected response is always swallowed, even when the
  // output register is full, so it never blocks the restart.
  assign imem_rsp_ready_o = (state == IFU_WAIT) &&
                            (out_in_ready || kill || redirect_valid_i);

  assign req_fire = imem_req_valid_o && imem_req_ready_i;
  assign rsp_fire = imem_rsp_valid_i && imem_rsp_ready_o;

  // Redirect is fed as flush, so the pipe register also refuses the word.
  assign out_in_valid = (state == IFU_WAIT) && imem_rsp_valid_i && !kill;
  assign out_in_data  = '{pc: pc, inst: imem_rsp_data_i};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IFU_IDLE;
      pc    <= RESET_PC;
      kill  <= 1'b0;
    end else begin
      case (state)
        IFU_IDLE: state <= IFU_REQ;
        IFU_REQ: begin
          if (redirect_valid_i) pc <= align_pc(redirect_pc_i);
          if (req_fire) begin
            state <= IFU_WAIT;
            // Accepted request belongs to the old path: drop its response.
            kill  <= redirect_valid_i;
          end
        end
        IFU_WAIT: begin
          if (redirect_valid_i) begin
            pc <= align_pc(redirect_pc_i);
            if (imem_rsp_valid_i) begin
              state <= IFU_REQ;
              kill  <= 1'b0;
            end else begin
              kill  <= 1'b1;
            end
          end else if (rsp_fire) begin
            state <= IFU_REQ;
            kill  <= 1'b0;
            if (!kill) pc <= pc + 32'd4;
          end
        end
        default: state <= IFU_IDLE;
      endcase
    end
  end

  liang_pipe_reg #(.T(ifToId_t)) u_out_reg (
    .clk       (clk),
    .rst       (rst),
    .flush     (redirect_valid_i),
    .in_valid  (out_in_valid),
    .in_ready  (out_in_ready),
    .in_data   (out_in_data),
    .out_valid (if_valid_o),
    .out_ready (if_ready_i),
    .out_data  (if_data_o)
  );

endmodule

// File: tb/tb_liang_ifu.sv
module tb_liang_ifu;
  import liang_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        redirect_valid_i = 1'b0;
  logic [31:0] redirect_pc_i    = '0;
  logic        imem_req_valid_o;
  logic        imem_req_ready_i;
  logic [31:0] imem_req_addr_o;
  logic        imem_rsp_valid_i;
  logic [31:0] imem_rsp_data_i;
  logic        imem_rsp_ready_o;
  logic        if_valid_o;
  logic        if_ready_i = 1'b1;
  logic [63:0] if_data_o;

  liang_ifu dut (
    .clk              (clk),
    .rst              (rst),
    .redirect_valid_i (redirect_valid_i),
    .redirect_pc_i    (redirect_pc_i),
    .imem_req_valid_o (imem_req_valid_o),
    .imem_req_ready_i (imem_req_ready_i),
    .imem_req_addr_o  (imem_req_addr_o),
    .imem_rsp_valid_i (imem_rsp_valid_i),
    .imem_rsp_data_i  (imem_rsp_data_i),
    .imem_rsp_ready_o (imem_rsp_ready_o),
    .if_valid_o       (if_valid_o),
    .if_ready_i       (if_ready_i),
    .if_data_o        (if_data_o)
  );

  // ---------------- scoreboard ----------------
  int errors = 0;
  int checks = 0;
  logic [31:0] req_q[$];
  logic [63:0] exp_q[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------- memory model ----------------
  int          mem_lat = 1;
  int          budget  = 0;
  logic        busy    = 1'b0;
  int          cnt     = 0;
  logic [31:0] mem_addr = '0;
  logic        req_hs, rsp_hs;
  logic [31:0] hs_addr;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[23:0], 8'h13};
  endfunction

  initial begin
    imem_req_ready_i = 1'b0;
    imem_rsp_valid_i = 1'b0;
    imem_rsp_data_i  = '0;
    forever begin
      @(negedge clk);
      req_hs  = !rst && imem_req_valid_o && imem_req_ready_i;
      rsp_hs  = !rst && imem_rsp_valid_i && imem_rsp_ready_o;
      hs_addr = imem_req_addr_o;
      @(posedge clk); #1;
      if (rst) begin
        busy = 1'b0;
        imem_rsp_valid_i = 1'b0;
        imem_req_ready_i = 1'b0;
      end else begin
        if (rsp_hs) begin
          imem_rsp_valid_i = 1'b0;
          busy = 1'b0;
        end
        if (req_hs) begin
          busy = 1'b1;
          cnt = mem_lat;
          mem_addr = hs_addr;
          budget--;
        end
        if (busy && !imem_rsp_valid_i) begin
          if (cnt <= 1) begin
            imem_rsp_valid_i = 1'b1;
            imem_rsp_data_i  = mem_word(mem_addr);
          end else begin
            cnt--;
          end
        end
        imem_req_ready_i = !busy && (budget > 0);
      end
    end
  end

  // ---------------- monitors ----------------
  logic [31:0] req_exp;
  logic [63:0] out_exp;

  always @(negedge clk) begin
    if (!rst && imem_req_valid_o && imem_req_ready_i) begin
      if (req_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL req_unexpected: got addr %h expected no request", imem_req_addr_o);
      end else begin
        req_exp = req_q.pop_front();
        check("req_addr", {32'h0, imem_req_addr_o}, {32'h0, req_exp});
      end
    end
  end

  always @(negedge clk) begin
    if (!rst && if_valid_o && if_ready_i && !redirect_valid_i) begin
      if (exp_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL out_unexpected: got %h expected no output", if_data_o);
      end else begin
        out_exp = exp_q.pop_front();
        check("if_data", if_data_o, out_exp);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk); #2;
  endtask

  task automatic drain(input string name);
    int n = 0;
    while ((req_q.size() != 0 || exp_q.size() != 0) && n < 60) begin
      step();
      n++;
    end
    checks++;
    if (req_q.size() != 0 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s_drain: got %0d reqs %0d outs pending expected 0", name, req_q.size(), exp_q.size());
    end
    repeat (4) step();
  endtask

  task automatic pulse_redirect(input logic [31:0] target);
    redirect_valid_i = 1'b1;
    redirect_pc_i    = target;
    step();
    redirect_valid_i = 1'b0;
  endtask

  task automatic timeout_fail(input string name);
    checks++; errors++;
    $display("FAIL %s_timeout: got no event expected one within 50 cycles", name);
  endtask

  // ---------------- directed tests ----------------
  initial begin
    int n;
    repeat (3) @(posedge clk);

    // Reset state.
    @(negedge clk);
    check("rst_req_valid", imem_req_valid_o, 0);
    check("rst_rsp_ready", imem_rsp_ready_o, 0);
    check("rst_if_valid", if_valid_o, 0);
    check("rst_if_data", if_data_o, 0);

    // T1: reset release, 1-cycle memory, decode ready.
    budget = 2;
    req_q.push_back(32'h8000_0000);
    req_q.push_back(32'h8000_0004);
    exp_q.push_back(64'h8000_0000_0000_0013);
    exp_q.push_back(64'h8000_0004_0000_0413);
    @(posedge clk); #2; rst = 1'b0;
    @(negedge clk);
    check("t1_idle_no_req", imem_req_valid_o, 0);
    @(negedge clk);
    check("t1_first_req_valid", imem_req_valid_o, 1);
    check("t1_first_req_addr", imem_req_addr_o, 32'h8000_0000);
    @(negedge clk);
    check("t1_wait_if_valid", if_valid_o, 0);
    @(negedge clk);
    check("t1_out_valid", if_valid_o, 1);
    check("t1_out_data", if_data_o, 64'h8000_0000_0000_0013);
    check("t1_second_req_valid", imem_req_valid_o, 1);
    check("t1_second_req_addr", imem_req_addr_o, 32'h8000_0004);
    drain("t1");

    // T2: decode stalled with output full -> response backpressured.
    if_ready_i = 1'b0;
    budget = 2;
    req_q.push_back(32'h8000_0008);
    req_q.push_back(32'h8000_000C);
    exp_q.push_back(64'h8000_0008_0000_0813);
    exp_q.push_back(64'h8000_000C_0000_0C13);
    n = 0;
    while (!(imem_rsp_valid_i && if_valid_o) && n < 50) begin step(); n++; end
    if (n >= 50) timeout_fail("t2");
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("t2_rsp_ready_low", imem_rsp_ready_o, 0);
      check("t2_data_stable", if_data_o, 64'h8000_0008_0000_0813);
      check("t2_pc_stable", imem_req_addr_o, 32'h8000_000C);
    end
    step();
    if_ready_i = 1'b1;
    drain("t2");

    // T3: redirect in WAIT, response arrives 3 cycles after acceptance.
    mem_lat = 3;
    budget = 2;
    req_q.push_back(32'h8000_0010);
    req_q.push_back(32'h8000_0100);
    exp_q.push_back(64'h8000_0100_0001_0013);
    n = 0;
    while (!(busy && !imem_rsp_valid_i) && n < 50) begin step(); n++; end
    if (n >= 50) timeout_fail("t3");
    pulse_redirect(32'h8000_0100);
    drain("t3");
    mem_lat = 1;

    // T4: redirect to a misaligned PC in the same cycle as a response.
    budget = 2;
    req_q.push_back(32'h8000_0104);
    req_q.push_back(32'h8000_0040);
    exp_q.push_back(64'h8000_0040_0000_4013);
    n = 0;
    while (!(busy && imem_rsp_valid_i) && n < 50) begin step(); n++; end
    if (n >= 50) timeout_fail("t4");
    pulse_redirect(32'h8000_0043);
    drain("t4");

    // T5: redirect in the same cycle as request acceptance.
    budget = 2;
    req_q.push_back(32'h8000_0044);
    req_q.push_back(32'h8000_0200);
    exp_q.push_back(64'h8000_0200_0002_0013);
    n = 0;
    while (!(imem_req_valid_o && imem_req_ready_i) && n < 50) begin step(); n++; end
    if (n >= 50) timeout_fail("t5");
    pulse_redirect(32'h8000_0200);
    drain("t5");

    // T6: redirect to the top word, then PC wraps to zero.
    pulse_redirect(32'hFFFF_FFFC);
    req_q.push_back(32'hFFFF_FFFC);
    req_q.push_back(32'h0000_0000);
    exp_q.push_back(64'hFFFF_FFFC_FFFF_FC13);
    exp_q.push_back(64'h0000_0000_0000_0013);
    budget = 2;
    drain("t6");
    @(negedge clk);
    check("t6_wrapped_pc", imem_req_addr_o, 32'h0000_0004);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
